program_sequencer_stack: RTL and testbench
==========================================

// Module: program_sequencer_stack
// PURPOSE
//  Parametrised next-generation program sequencer with subroutine support.
//  Generates the program-memory fetch address (pm_addr, combinational) and holds the current pc (registered).
//  Adds call/return through a hardware return-address stack, a pipeline stall, and sticky stack-error flags.
//  Sits between the instruction decoder and the synchronous program memory.
// PARAMETERS
//  ADDR_W       8   width of pm_addr and pc
//  JMP_W        4   width of jmp_addr; jump target = {jmp_addr, (ADDR_W-JMP_W)'b0}; requires JMP_W <= ADDR_W
//  STACK_DEPTH  4   return-stack entries, >= 1
//  RESET_ADDR   0   first fetch address after any reset
// PORTS
//  clk              in   1        single clock, rising edge
//  reset_n          in   1        one clock; reset is asynchronous and active-low
//  sync_reset       in   1        synchronous restart, active-high
//  stall            in   1        hold pc; no stack change
//  jmp              in   1        unconditional jump
//  jmp_nz           in   1        conditional jump
//  dont_jump        in   1        condition false; suppresses jmp_nz only
//  call             in   1        push return address, then jump
//  ret              in   1        pop return address, then jump to it
//  jmp_addr         in   JMP_W    jump/call target, high bits
//  pm_addr          out  ADDR_W   next fetch address (combinational)
//  pc               out  ADDR_W   registered address of the executing instruction
//  stack_level      out  clog2(STACK_DEPTH+1)  occupied stack entries
//  stack_overflow   out  1        sticky: call issued with stack full
//  stack_underflow  out  1        sticky: ret issued with stack empty
// BEHAVIOUR
//  reset_n=0 (async):
//   - pc=RESET_ADDR; stack_level=0; both error flags 0
//   - start flag set; pm_addr=RESET_ADDR while start is set
//   - start clears on the first clk edge after release, so pc=RESET_ADDR is fetched exactly once
//  Every posedge clk: pc <= pm_addr. Stack and flag updates occur on the same edge.
//  pm_addr priority, highest first; ignored lower-priority requests have no effect:
//   1. start or sync_reset -> RESET_ADDR
//      sync_reset also clears stack_level and both error flags
//   2. stall -> pc
//   3. ret, stack non-empty -> top entry; pop
//      ret, stack empty -> pc+1; stack_underflow<=1
//   4. call -> target
//      stack not full: push pc+1
//      stack full: no push, contents unchanged, stack_overflow<=1
//   5. jmp -> target
//   6. jmp_nz & ~dont_jump -> target
//   7. otherwise -> pc+1
//  Arithmetic and stack rules:
//   - pc+1 is modulo 2^ADDR_W (all-ones wraps to 0)
//   - pushed return address wraps the same way
//   - Stack is LIFO, STACK_DEPTH entries; stack_level ranges 0..STACK_DEPTH
//   - Stack entries are not cleared by reset; only the level is
//   - Error flags clear only on reset_n or sync_reset
//  Latency: request decoded combinationally; new target visible on pm_addr in the same cycle; in pc one cycle later.
//  No handshake: the decoder must hold stall while program memory or the datapath is not ready.
// TESTING
//  1. Release reset_n, no requests, 5 clks -> pc sequence 0,0,1,2,3; pm_addr 0,1,2,3,4
//  2. At pc=0x12: jmp=1, jmp_addr=0xA -> pm_addr=0xA0, next pc=0xA0
//     jmp_nz=1 with dont_jump=1 -> pc+1
//  3. At pc=0x05: call, jmp_addr=0x3 -> pc=0x30, stack_level=1
//     Later ret -> pm_addr=0x06, stack_level=0
//  4. Five nested calls, STACK_DEPTH=4 -> 5th call still jumps; stack_level stays 4; stack_overflow=1
//     Four rets return to the correct addresses; a 5th ret gives pc+1 and stack_underflow=1
//  5. pc=0xFF, no request -> pm_addr=0x00
//     stall=1 together with jmp for 3 clks -> pc holds 0xFF; jmp is ignored
//  6. Apply sync_reset mid-subroutine (stack_level=2) -> pm_addr=0, stack_level=0, flags 0
//     Assert reset_n=0 between clock edges -> pc=0 immediately

Source files
------------

// File: rtl/program_sequencer_stack.sv
// Program sequencer: combinational fetch address, registered pc, hardware
// return-address stack with sticky overflow/underflow flags.
module program_sequencer_stack #(
    parameter int ADDR_W      = 8,
    parameter int JMP_W       = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0,
    localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sync_reset,
    input  logic              stall,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic              dont_jump,
    input  logic              call,
    input  logic              ret,
    input  logic [JMP_W-1:0]  jmp_addr,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [LVL_W-1:0]  stack_level,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam int IDX_W                 = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_ADDR);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

    logic              start_q;
    logic [ADDR_W-1:0] pc_q;
    logic [LVL_W-1:0]  level_q;
    logic              ovf_q;
    logic              unf_q;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] top_entry;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic              stack_empty;
    logic              stack_full;
    logic              ops_en;
    logic              do_push;
    logic              do_pop;
    logic              set_ovf;
    logic              set_unf;

    assign pc_inc      = pc_q + ADDR_W'(1);
    assign target      = ADDR_W'(jmp_addr) << (ADDR_W - JMP_W);
    assign stack_empty = (level_q == '0);
    assign stack_full  = (level_q == FULL_LVL);
    assign top_idx     = IDX_W'(level_q - LVL_W'(1));
    assign push_idx    = IDX_W'(level_q);
    assign top_entry   = stack_mem[top_idx];

    // Stack only moves when no higher-priority restart or stall owns the cycle;
    // ret outranks call when both are requested.
    assign ops_en  = ~start_q & ~sync_reset & ~stall;
    assign do_pop  = ops_en & ret & ~stack_empty;
    assign set_unf = ops_en & ret & stack_empty;
    assign do_push = ops_en & ~ret & call & ~stack_full;
    assign set_ovf = ops_en & ~ret & call & stack_full;

    always_comb begin
        pm_addr = pc_inc;
        if (start_q || sync_reset) begin
            pm_addr = RST_PC;
        end else if (stall) begin
            pm_addr = pc_q;
        end else if (ret) begin
            pm_addr = stack_empty ? pc_inc : top_entry;
        end else if (call || jmp || (jmp_nz && !dont_jump)) begin
            pm_addr = target;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b1;
            pc_q    <= RST_PC;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            pc_q    <= pm_addr;
            if (sync_reset) begin
                level_q <= '0;
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
            end else begin
                if (do_pop) begin
                    level_q <= level_q - LVL_W'(1);
                end else if (do_push) begin
                    level_q <= level_q + LVL_W'(1);
                end
                if (set_ovf) begin
                    ovf_q <= 1'b1;
                end
                if (set_unf) begin
                    unf_q <= 1'b1;
                end
            end
        end
    end

    // Entries survive resets; only the level pointer is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    assign pc              = pc_q;
    assign stack_level     = level_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Bench for program_sequencer_stack: directed vector table, corner sequences,
// then random requests checked against a queue-based reference model.
module tb_program_sequencer_stack;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sync_reset = 1'b0;
    logic       stall = 1'b0;
    logic       jmp = 1'b0;
    logic       jmp_nz = 1'b0;
    logic       dont_jump = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [3:0] jmp_addr = 4'h0;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic [2:0] stack_level;
    logic       stack_overflow;
    logic       stack_underflow;

    program_sequencer_stack dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sync_reset     (sync_reset),
        .stall          (stall),
        .jmp            (jmp),
        .jmp_nz         (jmp_nz),
        .dont_jump      (dont_jump),
        .call           (call),
        .ret            (ret),
        .jmp_addr       (jmp_addr),
        .pm_addr        (pm_addr),
        .pc             (pc),
        .stack_level    (stack_level),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       sr, st, j, jnz, dj, c, r;
        bit [3:0] ja;
    } in_t;

    typedef struct {
        in_t in;
        int  pm;
        int  lvl;
        bit  ovf, unf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit   m_start;
    int   m_pc;
    int   m_q[$];
    bit   m_ovf, m_unf;
    int   last_pm;
    vec_t tab[$];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic in_t mk(bit sr, bit st, bit j, bit jnz, bit dj, bit c, bit r, bit [3:0] ja);
        in_t i;
        i.sr = sr; i.st = st; i.j = j; i.jnz = jnz; i.dj = dj; i.c = c; i.r = r; i.ja = ja;
        return i;
    endfunction

    function automatic in_t nop();              return mk(0,0,0,0,0,0,0,4'h0); endfunction
    function automatic in_t jp(bit [3:0] a);    return mk(0,0,1,0,0,0,0,a);    endfunction
    function automatic in_t cl(bit [3:0] a);    return mk(0,0,0,0,0,1,0,a);    endfunction
    function automatic in_t rt();               return mk(0,0,0,0,0,0,1,4'h0); endfunction

    task automatic addv(input in_t i, input int pm, input int lvl, input bit o, input bit u);
        vec_t v;
        v.in = i; v.pm = pm; v.lvl = lvl; v.ovf = o; v.unf = u;
        tab.push_back(v);
    endtask

    task automatic model_reset();
        m_start = 1'b1;
        m_pc    = 0;
        m_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    function automatic int model_pm(input in_t i);
        int inc = (m_pc + 1) % 256;
        int tgt = i.ja * 16;
        if (m_start || i.sr)          return 0;
        if (i.st)                     return m_pc;
        if (i.r)                      return (m_q.size() > 0) ? m_q[$] : inc;
        if (i.c || i.j)               return tgt;
        if (i.jnz && !i.dj)           return tgt;
        return inc;
    endfunction

    task automatic model_update(input in_t i, input int nxt);
        if (i.sr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!m_start && !i.st) begin
            if (i.r) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
                else m_unf = 1'b1;
            end else if (i.c) begin
                if (m_q.size() < 4) m_q.push_back((m_pc + 1) % 256);
                else m_ovf = 1'b1;
            end
        end
        m_pc    = nxt;
        m_start = 1'b0;
    endtask

    task automatic cycle(input in_t i);
        int exp_pm;
        @(negedge clk);
        sync_reset = i.sr; stall = i.st; jmp = i.j; jmp_nz = i.jnz;
        dont_jump  = i.dj; call = i.c; ret = i.r; jmp_addr = i.ja;
        #1;
        exp_pm  = model_pm(i);
        last_pm = int'(pm_addr);
        check("pm_addr", pm_addr, exp_pm);
        @(posedge clk);
        #1;
        model_update(i, exp_pm);
        check("pc", pc, m_pc);
        check("stack_level", stack_level, m_q.size());
        check("stack_overflow", stack_overflow, m_ovf);
        check("stack_underflow", stack_underflow, m_unf);
    endtask

    initial begin
        in_t ri;

        // after-reset sequence, jumps, a call/ret, nesting past the top and bottom
        addv(nop(), 8'h00, 0, 0, 0);
        addv(nop(), 8'h01, 0, 0, 0);
        addv(nop(), 8'h02, 0, 0, 0);
        addv(nop(), 8'h03, 0, 0, 0);
        addv(nop(), 8'h04, 0, 0, 0);
        addv(jp(4'h1), 8'h10, 0, 0, 0);
        addv(nop(), 8'h11, 0, 0, 0);
        addv(nop(), 8'h12, 0, 0, 0);
        addv(jp(4'hA), 8'hA0, 0, 0, 0);
        addv(mk(0,0,0,1,1,0,0,4'h5), 8'hA1, 0, 0, 0);
        addv(mk(0,0,0,1,0,0,0,4'h0), 8'h00, 0, 0, 0);
        for (int k = 1; k <= 5; k++) addv(nop(), k, 0, 0, 0);
        addv(cl(4'h3), 8'h30, 1, 0, 0);
        addv(nop(), 8'h31, 1, 0, 0);
        addv(rt(), 8'h06, 0, 0, 0);
        addv(cl(4'h1), 8'h10, 1, 0, 0);
        addv(cl(4'h2), 8'h20, 2, 0, 0);
        addv(cl(4'h3), 8'h30, 3, 0, 0);
        addv(cl(4'h4), 8'h40, 4, 0, 0);
        addv(cl(4'h5), 8'h50, 4, 1, 0);
        addv(rt(), 8'h31, 3, 1, 0);
        addv(rt(), 8'h21, 2, 1, 0);
        addv(rt(), 8'h11, 1, 1, 0);
        addv(rt(), 8'h07, 0, 1, 0);
        addv(rt(), 8'h08, 0, 1, 1);
        addv(mk(0,0,0,0,0,1,1,4'h9), 8'h09, 0, 1, 1);
        addv(mk(0,0,1,0,0,1,0,4'h2), 8'h20, 1, 1, 1);
        addv(mk(0,1,0,0,0,0,1,4'h0), 8'h20, 1, 1, 1);
        addv(mk(1,0,0,0,0,1,0,4'h7), 8'h00, 0, 0, 0);

        model_reset();
        #12;
        check("rst_pc", pc, 0);
        check("rst_pm", pm_addr, 0);
        check("rst_level", stack_level, 0);
        check("rst_flags", {stack_overflow, stack_underflow}, 0);
        #5 reset_n = 1'b1;

        foreach (tab[k]) begin
            cycle(tab[k].in);
            check("tab_pm", last_pm, tab[k].pm);
            check("tab_pc", pc, tab[k].pm);
            check("tab_level", stack_level, tab[k].lvl);
            check("tab_ovf", stack_overflow, tab[k].ovf);
            check("tab_unf", stack_underflow, tab[k].unf);
        end

        // wrap at 0xFF and stall outranking jmp
        cycle(jp(4'hF));
        repeat (15) cycle(nop());
        check("pc_ff", pc, 8'hFF);
        repeat (3) begin
            cycle(mk(0,1,1,0,0,0,0,4'h3));
            check("stall_hold", pc, 8'hFF);
        end
        cycle(nop());
        check("wrap_pm", last_pm, 8'h00);

        // sync_reset mid-subroutine clears level and flags
        cycle(rt());
        cycle(cl(4'h2));
        cycle(cl(4'h4));
        check("nest_level", stack_level, 2);
        cycle(mk(1,0,0,0,0,1,0,4'h6));
        check("sr_pm", last_pm, 0);
        check("sr_level", stack_level, 0);
        check("sr_unf", stack_underflow, 0);

        // asynchronous reset between edges
        cycle(jp(4'h5));
        #1 reset_n = 1'b0;
        #1;
        check("async_pc", pc, 0);
        check("async_pm", pm_addr, 0);
        check("async_level", stack_level, 0);
        #1 reset_n = 1'b1;
        model_reset();

        for (int n = 0; n < 600; n++) begin
            ri.sr  = ($urandom_range(0, 39) == 0);
            ri.st  = ($urandom_range(0, 5) == 0);
            ri.j   = ($urandom_range(0, 5) == 0);
            ri.jnz = ($urandom_range(0, 3) == 0);
            ri.dj  = $urandom_range(0, 1) == 1;
            ri.c   = ($urandom_range(0, 3) == 0);
            ri.r   = ($urandom_range(0, 3) == 0);
            ri.ja  = 4'($urandom_range(0, 15));
            cycle(ri);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
